// File: rtl/fetch_ctrl_pkg.sv
// Shared definitions for the instruction fetch controller: state encodings,
// next-pc action codes, the EBREAK opcode and byte/word address helpers.
package fetch_ctrl_pkg;

  // Encoding 3 is never assigned and is treated as HALT wherever state is decoded.
  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } fetch_state_e;

  typedef enum logic [2:0] {
    ACT_HOLD       = 3'd0,
    ACT_FETCH      = 3'd1,
    ACT_REDIRECT   = 3'd2,
    ACT_BAD_TARGET = 3'd3,
    ACT_EBREAK     = 3'd4,
    ACT_RUNOFF     = 3'd5
  } pc_action_e;

  localparam logic [31:0] EBREAK_INSN = 32'h0010_0073;
  localparam int          WORD_SHIFT  = 2;
  localparam logic [31:0] PC_STEP     = 32'd4;

  function automatic logic [31:0] byte_to_word(input logic [31:0] byte_addr);
    return byte_addr >> WORD_SHIFT;
  endfunction

endpackage

// File: rtl/fetch_ctrl_if.sv
// Instruction memory port of the fetch controller.
// The memory answers reads combinationally from imem_addr (no valid/ready);
// it writes imem_wdata at word imem_addr>>2 on any rising edge where imem_we=1.
interface fetch_ctrl_if;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_we;
  logic [31:0] imem_wdata;

  modport master (
    output imem_addr,
    output imem_we,
    output imem_wdata,
    input  imem_rdata
  );

  modport slave (
    input  imem_addr,
    input  imem_we,
    input  imem_wdata,
    output imem_rdata
  );
endinterface

// File: rtl/fetch_ctrl_pc_next_logic.sv
// Combinational next-pc selection for the RUN state: decides what the current
// edge does (fetch, hold, redirect, halt) and the pc value that follows.
module pc_next_logic
  import fetch_ctrl_pkg::*;
#(
  parameter int MEM_WORDS = 256
) (
  input  logic [31:0] pc,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic [31:0] imem_rdata,
  output pc_action_e  action,
  output logic [31:0] pc_next
);

  // One extra bit so the limit and pc+4 compare without 32-bit wrap.
  localparam logic [32:0] PC_LIMIT = 33'(MEM_WORDS) << WORD_SHIFT;

  logic [32:0] seq_pc;
  logic        bad_target;

  assign seq_pc     = {1'b0, pc} + {1'b0, PC_STEP};
  assign bad_target = (redirect_pc[1:0] != 2'b00) || ({1'b0, redirect_pc} >= PC_LIMIT);

  always_comb begin
    action  = ACT_HOLD;
    pc_next = pc;
    if (redirect) begin
      if (bad_target) begin
        action = ACT_BAD_TARGET;
      end else begin
        action  = ACT_REDIRECT;
        pc_next = redirect_pc;
      end
    end else if (!stall) begin
      // The word at pc is always delivered; only the step past it may halt.
      if (imem_rdata == EBREAK_INSN) begin
        action = ACT_EBREAK;
      end else if (seq_pc >= PC_LIMIT) begin
        action = ACT_RUNOFF;
      end else begin
        action  = ACT_FETCH;
        pc_next = seq_pc[31:0];
      end
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: loads memory in BOOT, fetches one word per
// cycle in RUN with stall/redirect, and stops in HALT on EBREAK or a fault.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          MEM_WORDS = 256
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                boot_we,
  input  logic [31:0]         boot_addr,
  input  logic [31:0]         boot_data,
  input  logic                boot_done,
  input  logic                stall,
  input  logic                redirect,
  input  logic [31:0]         redirect_pc,
  fetch_ctrl_if.master        imem,
  output logic [31:0]         pc_out,
  output logic [31:0]         instr_out,
  output logic                instr_valid,
  output logic                fault,
  output logic [1:0]          state_out
);

  fetch_state_e state;
  logic [31:0]  pc;
  pc_action_e   action;
  logic [31:0]  pc_next;

  pc_next_logic #(
    .MEM_WORDS (MEM_WORDS)
  ) u_pc_next (
    .pc          (pc),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_rdata  (imem.imem_rdata),
    .action      (action),
    .pc_next     (pc_next)
  );

  // The loader owns the memory port only while booting; reset blocks writes.
  always_comb begin
    imem.imem_addr  = pc;
    imem.imem_we    = 1'b0;
    imem.imem_wdata = 32'h0;
    if (state == ST_BOOT) begin
      imem.imem_addr  = boot_addr;
      imem.imem_we    = boot_we & ~rst;
      imem.imem_wdata = boot_data;
    end
  end

  assign state_out = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_BOOT;
      pc          <= RESET_PC;
      pc_out      <= 32'h0;
      instr_out   <= 32'h0;
      instr_valid <= 1'b0;
      fault       <= 1'b0;
    end else begin
      case (state)
        ST_BOOT: begin
          if (boot_done) state <= ST_RUN;
        end
        ST_RUN: begin
          case (action)
            ACT_FETCH: begin
              pc_out      <= pc;
              instr_out   <= imem.imem_rdata;
              instr_valid <= 1'b1;
              pc          <= pc_next;
            end
            ACT_EBREAK: begin
              pc_out      <= pc;
              instr_out   <= imem.imem_rdata;
              instr_valid <= 1'b1;
              state       <= ST_HALT;
            end
            ACT_RUNOFF: begin
              // Last word is delivered; there is nothing beyond it to fetch.
              pc_out      <= pc;
              instr_out   <= imem.imem_rdata;
              instr_valid <= 1'b1;
              fault       <= 1'b1;
              state       <= ST_HALT;
            end
            ACT_REDIRECT: begin
              pc          <= pc_next;
              instr_valid <= 1'b0;
            end
            ACT_BAD_TARGET: begin
              instr_valid <= 1'b0;
              fault       <= 1'b1;
              state       <= ST_HALT;
            end
            default: ;
          endcase
        end
        default: begin
          instr_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
